threshold_monitor: RTL and testbench

//  Streaming consumer of 4-bit magnitude-compare results: accepts 4-bit samples over valid/ready,

---
 rtl/threshold_monitor_pkg.sv | 19 +
 rtl/comparator_4bit.sv | 15 +
 rtl/threshold_monitor.sv | 189 ++++++++++++++++++
 tb/tb_threshold_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the threshold monitor.
// Hysteresis state encoding plus running min/max reset values.
package threshold_monitor_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        ARMING   = 2'd1,
        ALARM    = 2'd2,
        CLEARING = 2'd3
    } state_t;

    localparam logic [3:0] MIN_INIT = 4'hF;
    localparam logic [3:0] MAX_INIT = 4'h0;

    function automatic logic alarm_level(input state_t s);
        return (s == ALARM) || (s == CLEARING);
    endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator.
// Exactly one of gt/eq/lt is high for any pair of inputs.
module comparator_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = a > b;
    assign eq = a == b;
    assign lt = a < b;

endmodule

// File: rtl/threshold_monitor.sv
// Debounced hi/lo threshold monitor with a one-entry status register.
// Define MINMAX_TRACK_EN to add running min/max tracking of accepted samples.
module threshold_monitor #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] sample,
    input  logic [3:0] thr_hi,
    input  logic [3:0] thr_lo,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_gt,
    output logic       out_eq,
    output logic       out_lt,
    output logic       out_alarm,
    output logic       out_rise,
    output logic       out_fall,
    output logic       cfg_err,
    output logic [3:0] out_min,
    output logic [3:0] out_max
);

    import threshold_monitor_pkg::*;

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_inc;

    logic hi_gt;
    logic hi_eq;
    logic hi_lt;
    logic lo_gt;
    logic lo_eq;
    logic lo_lt;
    logic above;
    logic below;
    logic cfg_bad;
    logic accept;
    logic unused_cmp;

    comparator_4bit u_cmp_hi (
        .a  (sample),
        .b  (thr_hi),
        .gt (hi_gt),
        .eq (hi_eq),
        .lt (hi_lt)
    );

    comparator_4bit u_cmp_lo (
        .a  (thr_lo),
        .b  (sample),
        .gt (lo_gt),
        .eq (lo_eq),
        .lt (lo_lt)
    );

    assign unused_cmp = hi_lt ^ lo_eq ^ lo_lt;

    assign above    = hi_gt;
    assign below    = lo_gt;
    assign cfg_bad  = thr_lo > thr_hi;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Saturating increment keeps the run count from wrapping.
    assign run_inc = (run >= DEB) ? DEB : run + ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NORMAL;
            run       <= '0;
            out_valid <= 1'b0;
            out_gt    <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            out_alarm <= 1'b0;
            out_rise  <= 1'b0;
            out_fall  <= 1'b0;
            cfg_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_gt    <= hi_gt;
            out_eq    <= hi_eq;
            out_lt    <= below;
            cfg_err   <= cfg_bad;
            out_rise  <= 1'b0;
            out_fall  <= 1'b0;
            out_alarm <= alarm_level(state);
            // Misconfigured thresholds freeze the debouncer for this beat.
            if (!cfg_bad) begin
                unique case (state)
                    NORMAL: begin
                        if (above && run_inc == DEB) begin
                            state     <= ALARM;
                            run       <= '0;
                            out_rise  <= 1'b1;
                            out_alarm <= 1'b1;
                        end else if (above) begin
                            state <= ARMING;
                            run   <= ONE;
                        end else begin
                            run <= '0;
                        end
                    end
                    ARMING: begin
                        if (above && run_inc == DEB) begin
                            state     <= ALARM;
                            run       <= '0;
                            out_rise  <= 1'b1;
                            out_alarm <= 1'b1;
                        end else if (above) begin
                            run <= run_inc;
                        end else begin
                            state <= NORMAL;
                            run   <= '0;
                        end
                    end
                    ALARM: begin
                        if (below && ONE == DEB) begin
                            state     <= NORMAL;
                            run       <= '0;
                            out_fall  <= 1'b1;
                            out_alarm <= 1'b0;
                        end else if (below) begin
                            state <= CLEARING;
                            run   <= ONE;
                        end else begin
                            run <= '0;
                        end
                    end
                    CLEARING: begin
                        if (below && run_inc == DEB) begin
                            state     <= NORMAL;
                            run       <= '0;
                            out_fall  <= 1'b1;
                            out_alarm <= 1'b0;
                        end else if (below) begin
                            run <= run_inc;
                        end else begin
                            state <= ALARM;
                            run   <= '0;
                        end
                    end
                    default: begin
                        state <= NORMAL;
                        run   <= '0;
                    end
                endcase
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MINMAX_TRACK_EN
    logic [3:0] min_r;
    logic [3:0] max_r;

    // Running extremes only move on accepted beats, so they stay
    // aligned with the held status beat while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_r <= MIN_INIT;
            max_r <= MAX_INIT;
        end else if (accept) begin
            if (sample <= min_r) begin
                min_r <= sample;
            end
            if (sample >= max_r) begin
                max_r <= sample;
            end
        end
    end

    assign out_min = min_r;
    assign out_max = max_r;
`else
    assign out_min = 4'h0;
    assign out_max = 4'h0;
`endif

endmodule

// File: tb/tb_threshold_monitor.sv
// Directed bench for threshold_monitor with a behavioural reference model.
// Honours MINMAX_TRACK_EN for the min/max expectations.
module tb_threshold_monitor;

    localparam int DEBOUNCE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sample;
    logic [3:0] thr_hi;
    logic [3:0] thr_lo;
    logic       out_valid;
    logic       out_ready;
    logic       out_gt;
    logic       out_eq;
    logic       out_lt;
    logic       out_alarm;
    logic       out_rise;
    logic       out_fall;
    logic       cfg_err;
    logic [3:0] out_min;
    logic [3:0] out_max;

    int n_tests = 0;
    int n_fail  = 0;

    threshold_monitor #(.DEBOUNCE(DEBOUNCE), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sample    (sample),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gt    (out_gt),
        .out_eq    (out_eq),
        .out_lt    (out_lt),
        .out_alarm (out_alarm),
        .out_rise  (out_rise),
        .out_fall  (out_fall),
        .cfg_err   (cfg_err),
        .out_min   (out_min),
        .out_max   (out_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: alarm level plus a streak of consecutive
    // qualifying samples; DEBOUNCE in a row flips the alarm.
    logic       m_valid;
    logic       m_gt, m_eq, m_lt, m_alarm, m_rise, m_fall, m_err;
    logic [3:0] m_min, m_max;
    int         streak;
    logic       lvl;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_gt = 0; m_eq = 0; m_lt = 0;
            m_alarm = 0; m_rise = 0; m_fall = 0; m_err = 0;
            lvl = 0; streak = 0;
`ifdef MINMAX_TRACK_EN
            m_min = 4'hF; m_max = 4'h0;
`else
            m_min = 4'h0; m_max = 4'h0;
`endif
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_gt  = sample > thr_hi;
            m_eq  = sample == thr_hi;
            m_lt  = sample < thr_lo;
            m_err = thr_lo > thr_hi;
            m_rise = 0;
            m_fall = 0;
            if (!m_err) begin
                if (lvl ? m_lt : m_gt) begin
                    streak++;
                    if (streak == DEBOUNCE) begin
                        lvl = !lvl;
                        streak = 0;
                        m_rise = lvl;
                        m_fall = !lvl;
                    end
                end else begin
                    streak = 0;
                end
            end
            m_alarm = lvl;
`ifdef MINMAX_TRACK_EN
            if (sample < m_min) m_min = sample;
            if (sample > m_max) m_max = sample;
`endif
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        check("in_ready", {7'd0, in_ready}, {7'd0, !m_valid || out_ready});
        check("out_valid", {7'd0, out_valid}, {7'd0, m_valid});
        check("out_min", {4'd0, out_min}, {4'd0, m_min});
        check("out_max", {4'd0, out_max}, {4'd0, m_max});
        if (m_valid) begin
            check("out_gt", {7'd0, out_gt}, {7'd0, m_gt});
            check("out_eq", {7'd0, out_eq}, {7'd0, m_eq});
            check("out_lt", {7'd0, out_lt}, {7'd0, m_lt});
            check("out_alarm", {7'd0, out_alarm}, {7'd0, m_alarm});
            check("out_rise", {7'd0, out_rise}, {7'd0, m_rise});
            check("out_fall", {7'd0, out_fall}, {7'd0, m_fall});
            check("cfg_err", {7'd0, cfg_err}, {7'd0, m_err});
        end
    end

    task automatic drive(input logic [3:0] s, input logic [3:0] hi,
                         input logic [3:0] lo);
        @(posedge clk); #1;
        in_valid = 1; sample = s; thr_hi = hi; thr_lo = lo;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
    endtask

    task automatic pin(input string name, input logic act, input logic exp);
        check(name, {7'd0, act}, {7'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; out_ready = 1;
        sample = 0; thr_hi = 0; thr_lo = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        pin("rst_out_valid", out_valid, 1'b0);
        pin("rst_in_ready", in_ready, 1'b1);
        pin("rst_alarm", out_alarm, 1'b0);
`ifdef MINMAX_TRACK_EN
        check("rst_min", {4'd0, out_min}, 8'h0F);
`else
        check("rst_min", {4'd0, out_min}, 8'h00);
`endif

        // Three samples above hi raise the alarm on the third only.
        drive(9, 8, 3);
        pin("t1_alarm_a", out_alarm, 1'b0);
        drive(9, 8, 3);
        pin("t1_rise_b", out_rise, 1'b0);
        drive(9, 8, 3);
        pin("t1_alarm_c", out_alarm, 1'b1);
        pin("t1_rise_c", out_rise, 1'b1);

        // Clearing interrupted by 5, then three below lo clear it.
        drive(2, 8, 3);
        pin("t2_alarm_a", out_alarm, 1'b1);
        drive(5, 8, 3);
        pin("t2_alarm_b", out_alarm, 1'b1);
        drive(2, 8, 3);
        drive(2, 8, 3);
        pin("t2_fall_d", out_fall, 1'b0);
        drive(2, 8, 3);
        pin("t2_alarm_e", out_alarm, 1'b0);
        pin("t2_fall_e", out_fall, 1'b1);

        // Equality with hi is not above.
        drive(8, 8, 3);
        pin("t3_gt", out_gt, 1'b0);
        pin("t3_eq", out_eq, 1'b1);
        pin("t3_alarm", out_alarm, 1'b0);

        // Downstream stall holds beat A while B waits.
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; sample = 10; thr_hi = 8; thr_lo = 3;
        @(posedge clk); #1;
        sample = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pin("t4_in_ready", in_ready, 1'b0);
            pin("t4_hold_gt", out_gt, 1'b1);
            pin("t4_hold_lt", out_lt, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        pin("t4_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        pin("t4_b_lt", out_lt, 1'b1);
        pin("t4_b_gt", out_gt, 1'b0);

        // Inverted thresholds flag cfg_err and freeze the debouncer.
        drive(12, 4, 9);
        pin("t5_cfg_err", cfg_err, 1'b1);
        pin("t5_gt", out_gt, 1'b1);
        pin("t5_alarm", out_alarm, 1'b0);

        // Reset while arming with a held beat.
        drive(9, 8, 3);
        out_ready = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; out_ready = 1;
        @(negedge clk);
        pin("t5_rst_valid", out_valid, 1'b0);
        drive(9, 8, 3);
        drive(9, 8, 3);
        pin("t5_no_alarm", out_alarm, 1'b0);
        drive(9, 8, 3);
        pin("t5_rise", out_rise, 1'b1);

        // Running min/max over a fresh stream.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        drive(7, 15, 0);
        drive(2, 15, 0);
        drive(14, 15, 0);
        drive(5, 15, 0);
`ifdef MINMAX_TRACK_EN
        check("t6_min", {4'd0, out_min}, 8'h02);
        check("t6_max", {4'd0, out_max}, 8'h0E);
`else
        check("t6_min", {4'd0, out_min}, 8'h00);
        check("t6_max", {4'd0, out_max}, 8'h00);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
